// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: op classes, Tnew/Tuse constants and forward-select encodings shared by the P5 hazard unit
package hazard_ctrl_pkg;
   typedef logic [3:0] op_t;
   localparam op_t OP_NOP = 4'd0;
   localparam op_t OP_ADD = 4'd1;
   localparam op_t OP_SUB = 4'd2;
   localparam op_t OP_ORI = 4'd3;
   localparam op_t OP_BEQ = 4'd4;
   localparam op_t OP_LW  = 4'd5;
   localparam op_t OP_SW  = 4'd6;
   localparam op_t OP_LUI = 4'd7;
   localparam op_t OP_JAL = 4'd8;
   localparam op_t OP_JR  = 4'd9;
   localparam logic [1:0] TNEW_NONE = 2'd0;
   localparam logic [1:0] TNEW_ALU  = 2'd1;
   localparam logic [1:0] TNEW_LW   = 2'd2;
   localparam logic [1:0] TNEW_JAL  = 2'd0;
   localparam logic [1:0] TUSE_BR   = 2'd0;
   localparam logic [1:0] TUSE_ALU  = 2'd1;
   localparam logic [1:0] TUSE_ST   = 2'd2;
   localparam logic [1:0] FWD_D_RF  = 2'b00;
   localparam logic [1:0] FWD_D_E   = 2'b01;
   localparam logic [1:0] FWD_D_M   = 2'b10;
   localparam logic [1:0] FWD_D_W   = 2'b11;
   localparam logic [1:0] FWD_E_REG = 2'b00;
   localparam logic [1:0] FWD_E_M   = 2'b01;
   localparam logic [1:0] FWD_E_W   = 2'b10;
   localparam logic       FWD_M_REG = 1'b0;
   localparam logic       FWD_M_W   = 1'b1;
   typedef struct packed {
      logic       rs_used;
      logic       rt_used;
      logic [1:0] tuse_rs;
      logic [1:0] tuse_rt;
      logic [1:0] tnew;
      logic       wr;
   } tuse_t;
   function automatic logic [1:0] sat_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode-stage request (op class, A1/A2/A3) and the stall/forward selects returned to the datapath
interface hazard_ctrl_if #(
   parameter int REG_AW = 5
);
   logic [3:0]        d_op;
   logic [REG_AW-1:0] d_a1;
   logic [REG_AW-1:0] d_a2;
   logic [REG_AW-1:0] d_a3;
   logic              stall;
   logic [1:0]        fwd_d_rs;
   logic [1:0]        fwd_d_rt;
   logic [1:0]        fwd_e_rs;
   logic [1:0]        fwd_e_rt;
   logic              fwd_m_rt;
   modport master (
      output d_op, d_a1, d_a2, d_a3,
      input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
   );
   modport slave (
      input  d_op, d_a1, d_a2, d_a3,
      output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
   );
endinterface

// File: rtl/hazard_tuse.sv
// hazard_tuse: op class -> source use times, source-used flags, result latency and write flag
module hazard_tuse
   import hazard_ctrl_pkg::*;
(
   input  op_t   op,
   output tuse_t info
);
   // Branch/jump read registers in D, ALU/memory ops in E, store data in M
   always_comb begin
      info         = '0;
      info.rs_used = op inside {OP_ADD, OP_SUB, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_JR};
      info.rt_used = op inside {OP_ADD, OP_SUB, OP_SW, OP_BEQ};
      info.tuse_rs = (op == OP_BEQ || op == OP_JR) ? TUSE_BR : TUSE_ALU;
      info.tuse_rt = (op == OP_BEQ) ? TUSE_BR : (op == OP_SW) ? TUSE_ST : TUSE_ALU;
      info.wr      = op inside {OP_ADD, OP_SUB, OP_ORI, OP_LUI, OP_LW, OP_JAL};
      info.tnew    = (op == OP_LW) ? TNEW_LW : (op == OP_JAL) ? TNEW_JAL : info.wr ? TNEW_ALU : TNEW_NONE;
   end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: P5 stall/forward unit; define HAZARD_FWD_EN for full forwarding, otherwise a stall-only interlock
module hazard_ctrl #(
   parameter int REG_AW        = 5,
   parameter int USE_RF_BYPASS = 1
) (
   input logic          clk,
   input logic          reset,
   hazard_ctrl_if.slave hz
);
   import hazard_ctrl_pkg::*;
   localparam int E = 0;
   localparam int M = 1;
   localparam int W = 2;
`ifdef HAZARD_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif
   localparam int N_STALL = (FWD_EN || USE_RF_BYPASS != 0) ? 2 : 3;
   localparam logic [REG_AW-1:0] A0 = '0;

   tuse_t                   dinfo;
   logic                    stall_c;
   logic [2:0][3:0]         op_q, op_d;
   logic [2:0][REG_AW-1:0]  a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
   logic [2:0][1:0]         tnew_q, tnew_d;
   logic                    unused_state;

   function automatic logic hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
      return a != A0 && a == b;
   endfunction

   hazard_tuse u_tuse (.op(hz.d_op), .info(dinfo));

   // Stall when a used D source is still pending in E/M (without forwarding: any in-flight writer)
   always_comb begin
      stall_c = 1'b0;
      for (int i = 0; i < N_STALL; i++) begin
         stall_c |= dinfo.rs_used && hit(hz.d_a1, a3_q[i]) && (!FWD_EN || tnew_q[i] > dinfo.tuse_rs);
         stall_c |= dinfo.rt_used && hit(hz.d_a2, a3_q[i]) && (!FWD_EN || tnew_q[i] > dinfo.tuse_rt);
      end
      hz.stall = stall_c;
   end

`ifdef HAZARD_FWD_EN
   function automatic logic [1:0] pick_d(input logic [REG_AW-1:0] a, input logic [2:0][REG_AW-1:0] a3,
                                         input logic [2:0][1:0] tn);
      return hit(a, a3[E]) ? ((tn[E] == 2'd0) ? FWD_D_E : FWD_D_RF) :
             hit(a, a3[M]) ? ((tn[M] == 2'd0) ? FWD_D_M : FWD_D_RF) :
             (USE_RF_BYPASS == 0 && hit(a, a3[W])) ? FWD_D_W : FWD_D_RF;
   endfunction

   function automatic logic [1:0] pick_e(input logic [REG_AW-1:0] a, input logic [2:0][REG_AW-1:0] a3,
                                         input logic [2:0][1:0] tn);
      return hit(a, a3[M]) ? ((tn[M] == 2'd0) ? FWD_E_M : FWD_E_REG) :
             hit(a, a3[W]) ? FWD_E_W : FWD_E_REG;
   endfunction

   // Nearest matching writer decides; a still-pending match blocks older stages rather than forwarding
   always_comb begin
      hz.fwd_d_rs = pick_d(hz.d_a1, a3_q, tnew_q);
      hz.fwd_d_rt = pick_d(hz.d_a2, a3_q, tnew_q);
      hz.fwd_e_rs = pick_e(a1_q[E], a3_q, tnew_q);
      hz.fwd_e_rt = pick_e(a2_q[E], a3_q, tnew_q);
      hz.fwd_m_rt = (op_q[M] == OP_SW && hit(a2_q[M], a3_q[W])) ? FWD_M_W : FWD_M_REG;
   end
`else
   // Interlock-only build: every consumer reads its pipeline register
   always_comb begin
      hz.fwd_d_rs = FWD_D_RF;
      hz.fwd_d_rt = FWD_D_RF;
      hz.fwd_e_rs = FWD_E_REG;
      hz.fwd_e_rt = FWD_E_REG;
      hz.fwd_m_rt = FWD_M_REG;
   end
`endif

   // E takes the D op or a bubble; M and W follow with tnew counting down to zero
   always_comb begin
      op_d   = {op_q[M], op_q[E], stall_c ? OP_NOP : hz.d_op};
      a1_d   = {a1_q[M], a1_q[E], stall_c ? A0 : hz.d_a1};
      a2_d   = {a2_q[M], a2_q[E], stall_c ? A0 : hz.d_a2};
      a3_d   = {a3_q[M], a3_q[E], (stall_c || !dinfo.wr) ? A0 : hz.d_a3};
      tnew_d = {TNEW_NONE, sat_dec(tnew_q[E]), stall_c ? TNEW_NONE : dinfo.tnew};
   end

   // Shadow pipeline registers; reset drops every in-flight writer
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q   <= {3{OP_NOP}};
         a1_q   <= '0;
         a2_q   <= '0;
         a3_q   <= '0;
         tnew_q <= '0;
      end else begin
         op_q   <= op_d;
         a1_q   <= a1_d;
         a2_q   <= a2_d;
         a3_q   <= a3_d;
         tnew_q <= tnew_d;
      end
   end

   assign unused_state = ^{op_q, a1_q, a2_q, tnew_q, dinfo};
endmodule
